wb_downsize_bridge: RTL and testbench
=====================================

// Module: wb_downsize_bridge
// PURPOSE
//  Wishbone width down-converter: one wide slave access in, one narrow master beat
//  out per active output lane, issued sequentially.
//  - Supports any power-of-two ratio and all byte-select patterns.
//  - Read data is reassembled into the wide word; ERR is propagated upward.
//  - Sits between a wide CPU/interconnect port and narrow peripherals (UART, SPI regs).
// PARAMETERS
//  ADDRESS_WIDTH   32  byte address width on both sides
//  IN_DATA_WIDTH   32  wide-side data width; multiple of 8, power of two
//  OUT_DATA_WIDTH  8   narrow-side data width; multiple of 8, power of two, <= IN_DATA_WIDTH
//  Derived: R = IN/OUT lanes; IB = IN/8; OB = OUT/8
// PORTS
//  clk   input   1   clock
//  rstn  input   1   asynchronous active-low reset
//  in    wb_if.slave   IN_DATA_WIDTH    wide side: CYC STB WE ADR SEL[IB] DAT_W DAT_R ACK ERR
//  out   wb_if.master  OUT_DATA_WIDTH   narrow side: CYC STB WE ADR SEL[OB] DAT_W DAT_R ACK ERR
// BEHAVIOUR
//  Reset values: out.CYC/STB/WE = 0, out.ADR/SEL/DAT_W = 0, in.ACK/ERR = 0, in.DAT_R = 0, state IDLE.
//  Lanes and addressing:
//  - Lane k covers in.SEL[k*OB +: OB] and in.DAT_W/DAT_R[k*OUT +: OUT]. Little-endian.
//  - A lane is active iff its SEL slice != 0.
//  - Beat address = {latched ADR[AW-1:log2(IB)], k[log2(R)-1:0], log2(OB)'b0}.
//  - out.SEL = lane SEL slice; out.DAT_W = lane data slice; out.WE = latched WE.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE: when in.CYC & in.STB, latch ADR/SEL/DAT_W/WE and clear read accumulator.
//    - If SEL == 0: go to RESP with ACK and no narrow access.
//    - Otherwise load lowest active lane; next cycle out.CYC = out.STB = 1 (registered).
//  - ISSUE: hold out.* stable until out.ACK or out.ERR.
//    - On ACK: if read, store out.DAT_R in the lane slice.
//      - Next active lane exists: drop out.STB for exactly 1 cycle (keep out.CYC high),
//        then present the next lane.
//      - Else: drop out.CYC/STB, go to RESP (ACK).
//    - On ERR: abandon remaining lanes, drop out.CYC/STB, go to RESP (ERR).
//  - RESP: drive in.ACK or in.ERR for exactly 1 cycle with in.DAT_R = accumulator, then IDLE.
//  Read data: unselected and unvisited lanes read 0. in.DAT_R is held after RESP until the
//  next accepted access.
//  Latency: SEL=0 gives in.ACK 2 cycles after accept; otherwise sum of narrow beat
//  latencies + 1 gap per extra lane + 2.
//  Boundaries:
//  - ACK and ERR together on one beat: ERR wins.
//  - in.CYC drops while ISSUE: finish current beat (wait ACK/ERR), then IDLE; no in.ACK/ERR.
//  - in.STB held high in RESP: not re-accepted until back in IDLE; no back-to-back within 1 cycle.
//  - rstn low mid-operation: all outputs go to reset values immediately (async);
//    the partial access is lost.
//  - R == 1: single beat per access; pure registered pass-through.
// STRUCTURE
//  wb_bridge_pkg:
//  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} wb_br_state_e;
//  - clog2-based lane-count helpers.
//  Sub-module wb_lane_pick #(R, OB):
//  - Combinational next-active-lane finder from {SEL, current lane}.
//  - Outputs lane index and valid.
//  - Instantiated once; FSM, latches and accumulator live in the top.
// TESTING
//  - 32->8 write ADR=0x100 SEL=4'hF DAT_W=0xA1B2C3D4 -> 4 beats ADR 0x100..0x103,
//    DAT_W D4,C3,B2,A1, SEL=1; one in.ACK after 4th.
//  - 32->8 read ADR=0x200 SEL=4'b0110, slave returns 0x55, 0x66 -> beats at 0x201, 0x202
//    only; in.DAT_R=0x00665500.
//  - 32->8 write SEL=4'hF, slave ERRs 2nd beat -> no 3rd/4th beat; in.ERR=1 one cycle, in.ACK=0.
//  - SEL=4'h0 access -> out.CYC never rises; in.ACK one cycle, 2 cycles after accept.
//  - 64->16 read ADR=0x40 SEL=8'h30, slave returns 0xBEEF -> one beat ADR=0x44 SEL=2'b11;
//    in.DAT_R=0x0000BEEF_00000000.
//  - rstn=0 during 3rd beat of full write -> out.CYC=0 same cycle; after release a new read
//    completes normally.

Source files
------------

// File: rtl/wb_bridge_pkg.sv
// Shared types and lane-count helpers for the Wishbone width down-converter.
package wb_bridge_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} wb_br_state_e;

  // Number of narrow lanes that make up one wide word.
  function automatic int lane_count(int in_width, int out_width);
    return in_width / out_width;
  endfunction

  // Width of a lane index; kept at least one bit so a 1:1 bridge still has a legal vector.
  function automatic int lane_bits(int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bundle, parameterised on byte-address and data width.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_lane_pick.sv
// Finds the next narrow lane whose byte selects are non-zero.
// With 'first' set the search starts at lane 0 inclusive, otherwise strictly above 'cur'.
module wb_lane_pick
  import wb_bridge_pkg::*;
#(
  parameter int R  = 4,
  parameter int OB = 1,
  parameter int LW = lane_bits(R)
) (
  input  logic [R*OB-1:0] sel,
  input  logic [LW-1:0]   cur,
  input  logic            first,
  output logic [LW-1:0]   lane,
  output logic            valid
);

  // Scan from the top down so the lowest qualifying lane is the one left standing.
  always_comb begin
    valid = 1'b0;
    lane  = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if ((sel[k*OB +: OB] != '0) && (first || (k > int'(cur)))) begin
        valid = 1'b1;
        lane  = LW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_downsize_bridge.sv
// Wishbone width down-converter: one wide access becomes one narrow beat per active lane.
module wb_downsize_bridge
  import wb_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rstn,
  wb_if.slave  in,
  wb_if.master out
);

  localparam int R   = lane_count(IN_DATA_WIDTH, OUT_DATA_WIDTH);
  localparam int IB  = IN_DATA_WIDTH / 8;
  localparam int OB  = OUT_DATA_WIDTH / 8;
  localparam int LW  = lane_bits(R);
  localparam int OBL = $clog2(OB);
  localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(IB - 1);

  wb_br_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [IB-1:0]            sel_q, sel_d;
  logic [IN_DATA_WIDTH-1:0] dat_w_q, dat_w_d;
  logic                     we_q, we_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic [IN_DATA_WIDTH-1:0] acc_q, acc_d;
  logic                     gap_q, gap_d;
  logic                     abort_q, abort_d;
  logic                     resp_err_q, resp_err_d;
  logic                     out_cyc_q, out_cyc_d;
  logic                     out_stb_q, out_stb_d;
  logic                     in_ack_q, in_ack_d;
  logic                     in_err_q, in_err_d;
  logic [IN_DATA_WIDTH-1:0] in_dat_r_q, in_dat_r_d;

  logic          pick_first;
  logic [IB-1:0] pick_sel;
  logic [LW-1:0] pick_lane;
  logic          pick_valid;
  logic          abort_now;

  // In IDLE the search runs over the incoming selects; afterwards over the latched ones.
  assign pick_first = (state_q == IDLE);
  assign pick_sel   = pick_first ? in.sel : sel_q;
  assign abort_now  = abort_q | ~in.cyc;

  wb_lane_pick #(.R(R), .OB(OB), .LW(LW)) u_pick (
    .sel   (pick_sel),
    .cur   (lane_q),
    .first (pick_first),
    .lane  (pick_lane),
    .valid (pick_valid)
  );

  assign out.cyc   = out_cyc_q;
  assign out.stb   = out_stb_q;
  assign out.we    = we_q;
  assign out.adr   = adr_q | (ADDRESS_WIDTH'(lane_q) << OBL);
  assign out.sel   = sel_q[lane_q*OB +: OB];
  assign out.dat_w = dat_w_q[lane_q*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
  assign in.ack    = in_ack_q;
  assign in.err    = in_err_q;
  assign in.dat_r  = in_dat_r_q;

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      sel_q      <= '0;
      dat_w_q    <= '0;
      we_q       <= 1'b0;
      lane_q     <= '0;
      acc_q      <= '0;
      gap_q      <= 1'b0;
      abort_q    <= 1'b0;
      resp_err_q <= 1'b0;
      out_cyc_q  <= 1'b0;
      out_stb_q  <= 1'b0;
      in_ack_q   <= 1'b0;
      in_err_q   <= 1'b0;
      in_dat_r_q <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      dat_w_q    <= dat_w_d;
      we_q       <= we_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      gap_q      <= gap_d;
      abort_q    <= abort_d;
      resp_err_q <= resp_err_d;
      out_cyc_q  <= out_cyc_d;
      out_stb_q  <= out_stb_d;
      in_ack_q   <= in_ack_d;
      in_err_q   <= in_err_d;
      in_dat_r_q <= in_dat_r_d;
    end
  end

  // Next-state logic: accept, walk the active lanes with a one-cycle strobe gap, respond.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    dat_w_d    = dat_w_q;
    we_d       = we_q;
    lane_d     = lane_q;
    acc_d      = acc_q;
    gap_d      = gap_q;
    abort_d    = abort_q;
    resp_err_d = resp_err_q;
    out_cyc_d  = out_cyc_q;
    out_stb_d  = out_stb_q;
    in_ack_d   = 1'b0;
    in_err_d   = 1'b0;
    in_dat_r_d = in_dat_r_q;
    case (state_q)
      IDLE: begin
        // A response still showing on the wide side blocks a same-cycle re-accept.
        if (in.cyc && in.stb && !in_ack_q && !in_err_q) begin
          adr_d   = in.adr & ~LANE_MASK;
          sel_d   = in.sel;
          dat_w_d = in.dat_w;
          we_d    = in.we;
          acc_d   = '0;
          gap_d   = 1'b0;
          abort_d = 1'b0;
          if (pick_valid) begin
            lane_d    = pick_lane;
            out_cyc_d = 1'b1;
            out_stb_d = 1'b1;
            state_d   = ISSUE;
          end else begin
            resp_err_d = 1'b0;
            state_d    = RESP;
          end
        end
      end
      ISSUE: begin
        abort_d = abort_now;
        if (gap_q) begin
          gap_d = 1'b0;
          if (abort_now) begin
            out_cyc_d = 1'b0;
            out_stb_d = 1'b0;
            state_d   = IDLE;
          end else begin
            out_stb_d = 1'b1;
          end
        end else if (out.err) begin
          out_cyc_d  = 1'b0;
          out_stb_d  = 1'b0;
          resp_err_d = 1'b1;
          state_d    = abort_now ? IDLE : RESP;
        end else if (out.ack) begin
          if (!we_q) begin
            acc_d[lane_q*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = out.dat_r;
          end
          if (abort_now) begin
            out_cyc_d = 1'b0;
            out_stb_d = 1'b0;
            state_d   = IDLE;
          end else if (pick_valid) begin
            lane_d    = pick_lane;
            out_stb_d = 1'b0;
            gap_d     = 1'b1;
          end else begin
            out_cyc_d  = 1'b0;
            out_stb_d  = 1'b0;
            resp_err_d = 1'b0;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        in_ack_d   = ~resp_err_q;
        in_err_d   = resp_err_q;
        in_dat_r_d = acc_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_downsize_bridge.sv
// Scoreboard bench for the down-converter: a 32->8 instance and a 64->16 instance.
module tb_wb_downsize_bridge;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
  } beat_t;

  typedef struct packed {
    logic        err;
    logic [63:0] dat;
  } resp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  beat_t a_beat_q[$];
  beat_t b_beat_q[$];
  resp_t a_resp_q[$];
  resp_t b_resp_q[$];
  logic [7:0]  a_rd[$];
  logic [15:0] b_rd[$];
  int a_beat = 0;
  int a_err_beat = -1;
  int a_slave_wait = 0;
  int a_wait = 0;

  always #5 clk = ~clk;

  wb_if #(.AW(32), .DW(32)) a_i ();
  wb_if #(.AW(32), .DW(8))  a_o ();
  wb_if #(.AW(32), .DW(64)) b_i ();
  wb_if #(.AW(32), .DW(16)) b_o ();

  wb_downsize_bridge #(.ADDRESS_WIDTH(32), .IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(8)) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .in   (a_i),
    .out  (a_o)
  );

  wb_downsize_bridge #(.ADDRESS_WIDTH(32), .IN_DATA_WIDTH(64), .OUT_DATA_WIDTH(16)) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .in   (b_i),
    .out  (b_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mkBeat(input logic [31:0] adr, input logic [3:0] sel,
                                   input logic [31:0] dat, input logic we);
    beat_t b;
    b.adr = adr;
    b.sel = sel;
    b.dat = dat;
    b.we  = we;
    return b;
  endfunction

  // Narrow slave on the 32->8 side: checks each beat against the scoreboard, then responds.
  initial begin
    beat_t e;
    a_o.ack = 1'b0;
    a_o.err = 1'b0;
    a_o.dat_r = '0;
    forever begin
      @(negedge clk);
      if (a_o.ack || a_o.err) begin
        a_o.ack = 1'b0;
        a_o.err = 1'b0;
        a_o.dat_r = '0;
        checkOutput("a_stb_drop", 64'(a_o.stb), 64'd0);
      end else if (rstn && a_o.cyc && a_o.stb) begin
        if (a_wait < a_slave_wait) begin
          a_wait++;
        end else begin
          a_wait = 0;
          if (a_beat_q.size() == 0) begin
            checkOutput("a_extra_beat", 64'(a_beat_q.size()), 64'd1);
          end else begin
            e = a_beat_q.pop_front();
            checkOutput("a_beat_adr", 64'(a_o.adr), 64'(e.adr));
            checkOutput("a_beat_sel", 64'(a_o.sel), 64'(e.sel));
            checkOutput("a_beat_we", 64'(a_o.we), 64'(e.we));
            checkOutput("a_beat_dat", 64'(a_o.dat_w), 64'(e.dat));
          end
          if (a_beat == a_err_beat) begin
            a_o.err = 1'b1;
            a_o.ack = 1'b1;
          end else begin
            a_o.ack = 1'b1;
            a_o.dat_r = (a_rd.size() > 0) ? a_rd.pop_front() : 8'hEE;
          end
          a_beat++;
        end
      end
    end
  end

  // Narrow slave on the 64->16 side: zero-wait acknowledges.
  initial begin
    beat_t e;
    b_o.ack = 1'b0;
    b_o.err = 1'b0;
    b_o.dat_r = '0;
    forever begin
      @(negedge clk);
      if (b_o.ack) begin
        b_o.ack = 1'b0;
        b_o.dat_r = '0;
      end else if (rstn && b_o.cyc && b_o.stb) begin
        if (b_beat_q.size() == 0) begin
          checkOutput("b_extra_beat", 64'(b_beat_q.size()), 64'd1);
        end else begin
          e = b_beat_q.pop_front();
          checkOutput("b_beat_adr", 64'(b_o.adr), 64'(e.adr));
          checkOutput("b_beat_sel", 64'(b_o.sel), 64'(e.sel));
          checkOutput("b_beat_we", 64'(b_o.we), 64'(e.we));
          checkOutput("b_beat_dat", 64'(b_o.dat_w), 64'(e.dat));
        end
        b_o.ack = 1'b1;
        b_o.dat_r = (b_rd.size() > 0) ? b_rd.pop_front() : 16'hEEEE;
      end
    end
  end

  // One wide access on the 32->8 bridge; err_beat selects which narrow beat answers ERR.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input int err_beat, input bit hold);
    logic [63:0] exp_dat = '0;
    bit exp_err = 1'b0;
    int n = 0;
    int lat = 0;
    bit seen = 1'b0;
    resp_t e;
    a_beat = 0;
    a_err_beat = err_beat;
    for (int k = 0; k < 4; k++) begin
      if (sel[k] && !exp_err) begin
        a_beat_q.push_back(mkBeat({adr[31:2], 2'(k)}, 4'd1, 32'(dat[k*8 +: 8]), we));
        if (n == err_beat) exp_err = 1'b1;
        else if (!we) exp_dat[k*8 +: 8] = a_rd[n];
        n++;
      end
    end
    e.err = exp_err;
    e.dat = exp_dat;
    a_resp_q.push_back(e);
    @(negedge clk);
    a_i.cyc = 1'b1;
    a_i.stb = 1'b1;
    a_i.we = we;
    a_i.adr = adr;
    a_i.sel = sel;
    a_i.dat_w = dat;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (a_i.ack || a_i.err) seen = 1'b1;
    end
    e = a_resp_q.pop_front();
    checkOutput("a_resp_seen", 64'(seen), 64'd1);
    if (seen) begin
      checkOutput("a_resp_ack", 64'(a_i.ack), 64'(!e.err));
      checkOutput("a_resp_err", 64'(a_i.err), 64'(e.err));
      checkOutput("a_resp_dat", 64'(a_i.dat_r), e.dat);
      if (sel == 4'h0) checkOutput("a_sel0_latency", 64'(lat), 64'd2);
    end
    if (hold) @(negedge clk);
    a_i.cyc = 1'b0;
    a_i.stb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("a_resp_pulse", 64'({a_i.ack, a_i.err, a_o.cyc}), 64'd0);
    end
    checkOutput("a_beats_left", 64'(a_beat_q.size()), 64'd0);
    a_err_beat = -1;
  endtask

  // One wide access on the 64->16 bridge.
  task automatic applyWide(input logic we, input logic [31:0] adr, input logic [7:0] sel,
                           input logic [63:0] dat);
    logic [63:0] exp_dat = '0;
    int n = 0;
    int lat = 0;
    bit seen = 1'b0;
    resp_t e;
    for (int k = 0; k < 4; k++) begin
      if (sel[2*k +: 2] != 2'b00) begin
        b_beat_q.push_back(mkBeat({adr[31:3], 2'(k), 1'b0}, 4'(sel[2*k +: 2]),
                                  32'(dat[16*k +: 16]), we));
        if (!we) exp_dat[16*k +: 16] = b_rd[n];
        n++;
      end
    end
    e.err = 1'b0;
    e.dat = exp_dat;
    b_resp_q.push_back(e);
    @(negedge clk);
    b_i.cyc = 1'b1;
    b_i.stb = 1'b1;
    b_i.we = we;
    b_i.adr = adr;
    b_i.sel = sel;
    b_i.dat_w = dat;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (b_i.ack || b_i.err) seen = 1'b1;
    end
    e = b_resp_q.pop_front();
    checkOutput("b_resp_seen", 64'(seen), 64'd1);
    if (seen) begin
      checkOutput("b_resp_ack", 64'(b_i.ack), 64'd1);
      checkOutput("b_resp_dat", b_i.dat_r, e.dat);
    end
    b_i.cyc = 1'b0;
    b_i.stb = 1'b0;
    @(negedge clk);
    checkOutput("b_resp_pulse", 64'({b_i.ack, b_i.err, b_o.cyc}), 64'd0);
    checkOutput("b_beats_left", 64'(b_beat_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    a_i.cyc = 1'b0; a_i.stb = 1'b0; a_i.we = 1'b0;
    a_i.adr = '0;   a_i.sel = '0;   a_i.dat_w = '0;
    b_i.cyc = 1'b0; b_i.stb = 1'b0; b_i.we = 1'b0;
    b_i.adr = '0;   b_i.sel = '0;   b_i.dat_w = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_cyc", 64'(a_o.cyc), 64'd0);
    checkOutput("rst_out_stb", 64'(a_o.stb), 64'd0);
    checkOutput("rst_out_we", 64'(a_o.we), 64'd0);
    checkOutput("rst_out_adr", 64'(a_o.adr), 64'd0);
    checkOutput("rst_out_sel", 64'(a_o.sel), 64'd0);
    checkOutput("rst_out_dat", 64'(a_o.dat_w), 64'd0);
    checkOutput("rst_in_ack", 64'(a_i.ack), 64'd0);
    checkOutput("rst_in_err", 64'(a_i.err), 64'd0);
    checkOutput("rst_in_dat", 64'(a_i.dat_r), 64'd0);
    checkOutput("rst_b_cyc", 64'(b_o.cyc), 64'd0);
    checkOutput("rst_b_dat", b_i.dat_r, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] full write, four byte beats");
    applyStimulus(1'b1, 32'h0000_0100, 4'hF, 32'hA1B2_C3D4, -1, 1'b0);

    $display("[TB] sparse read, middle lanes only");
    a_rd.push_back(8'h55);
    a_rd.push_back(8'h66);
    applyStimulus(1'b0, 32'h0000_0200, 4'b0110, 32'h0, -1, 1'b0);

    $display("[TB] write with ERR (and ACK) on second beat");
    applyStimulus(1'b1, 32'h0000_0120, 4'hF, 32'hDEAD_BEEF, 1, 1'b0);

    $display("[TB] empty select, strobe held into response");
    applyStimulus(1'b1, 32'h0000_0140, 4'h0, 32'h1234_5678, -1, 1'b1);

    $display("[TB] full read with unaligned request address");
    a_rd.push_back(8'h11);
    a_rd.push_back(8'h22);
    a_rd.push_back(8'h33);
    a_rd.push_back(8'h44);
    applyStimulus(1'b0, 32'h0000_0213, 4'hF, 32'h0, -1, 1'b0);

    $display("[TB] 64->16 read and sparse write");
    b_rd.push_back(16'hBEEF);
    applyWide(1'b0, 32'h0000_0040, 8'h30, 64'h0);
    applyWide(1'b1, 32'h0000_0048, 8'hC3, 64'h1122_3344_5566_7788);

    $display("[TB] wide CYC dropped during a beat");
    a_slave_wait = 2;
    a_beat = 0;
    a_beat_q.push_back(mkBeat(32'h0000_0180, 4'd1, 32'h77, 1'b1));
    @(negedge clk);
    a_i.cyc = 1'b1; a_i.stb = 1'b1; a_i.we = 1'b1;
    a_i.adr = 32'h0000_0180; a_i.sel = 4'hF; a_i.dat_w = 32'h0000_0077;
    @(negedge clk);
    checkOutput("abort_cyc_up", 64'(a_o.cyc), 64'd1);
    a_i.cyc = 1'b0;
    a_i.stb = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 64'({a_i.ack, a_i.err}), 64'd0);
    end
    checkOutput("abort_cyc_down", 64'(a_o.cyc), 64'd0);
    checkOutput("abort_beats_left", 64'(a_beat_q.size()), 64'd0);
    a_slave_wait = 0;

    $display("[TB] reset during third beat of a full write");
    a_beat = 0;
    for (int k = 0; k < 4; k++)
      a_beat_q.push_back(mkBeat(32'h0000_0300 + 32'(k), 4'd1, 32'(8'h44 - 8'(k * 8'h11)), 1'b1));
    @(negedge clk);
    a_i.cyc = 1'b1; a_i.stb = 1'b1; a_i.we = 1'b1;
    a_i.adr = 32'h0000_0300; a_i.sel = 4'hF; a_i.dat_w = 32'h1122_3344;
    w = 0;
    while (!(a_o.cyc && a_o.stb && a_o.adr == 32'h0000_0302) && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rst_third_beat_seen", 64'(w < 50), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_cyc", 64'(a_o.cyc), 64'd0);
    checkOutput("rst_async_stb", 64'(a_o.stb), 64'd0);
    checkOutput("rst_async_adr", 64'(a_o.adr), 64'd0);
    a_i.cyc = 1'b0;
    a_i.stb = 1'b0;
    @(negedge clk);
    checkOutput("rst_hold_ack", 64'({a_i.ack, a_i.err}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    a_beat_q.delete();

    $display("[TB] read after reset release");
    a_rd.push_back(8'hAB);
    applyStimulus(1'b0, 32'h0000_0204, 4'b1000, 32'h0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
